// File: rtl/swir_clock_reset_sequencer.sv
// -----------------------------------------------------------------------------
// swir_clock_reset_sequencer
//
// Brings up the SWIR PLL and releases the downstream resets in order:
//   PLL_RST       -> hold the PLL in reset for PLL_RST_CYCLES cycles
//   WAIT_LOCK     -> wait for LOCK_STABLE_CYCLES consecutive locked cycles,
//                    retrying the PLL after LOCK_TIMEOUT_CYCLES
//   RELEASE_LOGIC -> release readout logic, wait STAGE_GAP_CYCLES
//   RUN           -> release sensor interface, report ready
// Loss of lock in RELEASE_LOGIC/RUN, or a force_relock request, restarts
// the sequence from PLL_RST.
//
// Ports:
//   clock           in   free-running reference clock
//   reset_n         in   asynchronous active-low reset
//   pll_locked      in   PLL lock indicator (asynchronous to clock)
//   force_relock    in   single-cycle request to restart the PLL
//   pll_rst         out  active-high PLL reset
//   logic_reset_n   out  active-low reset for the readout logic
//   sensor_reset_n  out  active-low reset for the sensor interface
//   ready           out  all domains released and lock held
//   state[2:0]      out  PLL_RST=0, WAIT_LOCK=1, RELEASE_LOGIC=2, RUN=3
//   lock_lost_count out  saturating count of lock-loss events
//   timeout_count   out  saturating count of lock timeouts
// -----------------------------------------------------------------------------
module swir_clock_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int STAGE_GAP_CYCLES    = 64
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       logic_reset_n,
  output logic       sensor_reset_n,
  output logic       ready,
  output logic [2:0] state,
  output logic [7:0] lock_lost_count,
  output logic [7:0] timeout_count
);

  // One shared cycle counter serves the PLL reset hold, the lock timeout and
  // the stage gap; size it for the largest of the three.
  localparam int CNT_MAX_A = (PLL_RST_CYCLES > STAGE_GAP_CYCLES) ? PLL_RST_CYCLES
                                                                  : STAGE_GAP_CYCLES;
  localparam int CNT_MAX   = (LOCK_TIMEOUT_CYCLES > CNT_MAX_A) ? LOCK_TIMEOUT_CYCLES
                                                               : CNT_MAX_A;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int STB_W     = $clog2(LOCK_STABLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_RELEASE   = 3'd2,
    S_RUN       = 3'd3
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic             sync1_q;
  logic             locked_s_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [STB_W-1:0] stable_q, stable_d;
  logic [7:0]       lost_q, lost_d;
  logic [7:0]       tmo_q, tmo_d;
  logic             pll_rst_q, logic_rstn_q, sensor_rstn_q, ready_q;

  // Two-flop synchronizer for the asynchronous lock indicator.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync1_q    <= pll_locked;
      locked_s_q <= sync1_q;
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_inc;
    stable_d = '0;
    lost_d   = lost_q;
    tmo_d    = tmo_q;
    case (state_q)
      S_PLL_RST: begin
        // force_relock is deliberately ignored here: the PLL is already in reset.
        if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        stable_d = locked_s_q ? stable_q + 1'b1 : '0;
        if (force_relock) begin
          state_d = S_PLL_RST;
        end else if (stable_d == STB_W'(LOCK_STABLE_CYCLES)) begin
          // A stable lock wins over a timeout landing on the same cycle.
          state_d = S_RELEASE;
        end else if (cnt_inc == CNT_W'(LOCK_TIMEOUT_CYCLES)) begin
          state_d = S_PLL_RST;
          tmo_d   = sat_inc(tmo_q);
        end
      end
      S_RELEASE, S_RUN: begin
        // Lock loss is checked first so a coincident force_relock still counts it.
        if (!locked_s_q) begin
          state_d = S_PLL_RST;
          lost_d  = sat_inc(lost_q);
        end else if (force_relock) begin
          state_d = S_PLL_RST;
        end else if (state_q == S_RELEASE && cnt_inc == CNT_W'(STAGE_GAP_CYCLES)) begin
          state_d = S_RUN;
        end else if (state_q == S_RUN) begin
          cnt_d = cnt_q;
        end
      end
      default: state_d = S_PLL_RST;
    endcase
    if (state_d != state_q) begin
      cnt_d    = '0;
      stable_d = '0;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as state and stay glitch-free registered values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_PLL_RST;
      cnt_q         <= '0;
      stable_q      <= '0;
      lost_q        <= '0;
      tmo_q         <= '0;
      pll_rst_q     <= 1'b1;
      logic_rstn_q  <= 1'b0;
      sensor_rstn_q <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stable_q      <= stable_d;
      lost_q        <= lost_d;
      tmo_q         <= tmo_d;
      pll_rst_q     <= (state_d == S_PLL_RST);
      logic_rstn_q  <= (state_d == S_RELEASE) || (state_d == S_RUN);
      sensor_rstn_q <= (state_d == S_RUN);
      ready_q       <= (state_d == S_RUN);
    end
  end

  assign pll_rst         = pll_rst_q;
  assign logic_reset_n   = logic_rstn_q;
  assign sensor_reset_n  = sensor_rstn_q;
  assign ready           = ready_q;
  assign state           = state_q;
  assign lock_lost_count = lost_q;
  assign timeout_count   = tmo_q;

endmodule

// File: tb/tb_swir_clock_reset_sequencer.sv
module tb_swir_clock_reset_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       force_relock;
  logic       pll_rst;
  logic       logic_reset_n;
  logic       sensor_reset_n;
  logic       ready;
  logic [2:0] state;
  logic [7:0] lock_lost_count;
  logic [7:0] timeout_count;

  swir_clock_reset_sequencer #(
    .PLL_RST_CYCLES      (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .STAGE_GAP_CYCLES    (4)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .pll_locked      (pll_locked),
    .force_relock    (force_relock),
    .pll_rst         (pll_rst),
    .logic_reset_n   (logic_reset_n),
    .sensor_reset_n  (sensor_reset_n),
    .ready           (ready),
    .state           (state),
    .lock_lost_count (lock_lost_count),
    .timeout_count   (timeout_count)
  );

  always #5 clock = ~clock;

  // {pll_rst, logic_reset_n, sensor_reset_n, ready, state, lost, timeout}
  logic [22:0] obs;
  assign obs = {pll_rst, logic_reset_n, sensor_reset_n, ready, state,
                lock_lost_count, timeout_count};

  function automatic logic [22:0] ev(input logic p, input logic l, input logic s,
                                     input logic r, input logic [2:0] st,
                                     input logic [7:0] lost, input logic [7:0] tmo);
    return {p, l, s, r, st, lost, tmo};
  endfunction

  typedef struct {
    logic        rst_n;
    logic        lock;
    logic        frc;
    logic [22:0] exp;
  } vec_t;

  vec_t vecs[19];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string tag, input logic [22:0] act, input logic [22:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, act, exp);
  endtask

  task automatic check8(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int budget, input string tag);
    bit hit = 1'b0;
    for (int k = 0; k < budget; k++) begin
      step();
      if (state === tgt) begin
        hit = 1'b1;
        break;
      end
    end
    n_total++;
    if (hit) n_pass++;
    else $display("FAIL %s: state %0d, want %0d within %0d cycles", tag, state, tgt, budget);
  endtask

  // Leaves reset released just after an edge; the next edge is edge 1.
  task automatic do_reset(input logic lock);
    reset_n      = 1'b0;
    pll_locked   = lock;
    force_relock = 1'b0;
    step_n(2);
    reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n      = 1'b0;
    pll_locked   = 1'b0;
    force_relock = 1'b0;

    // Clean lock from reset: pll_rst through edge 3, WAIT_LOCK edges 4..11,
    // RELEASE_LOGIC at edge 12, RUN at edge 16.
    vecs[0]  = '{1'b0, 1'b1, 1'b0, ev(1, 0, 0, 0, 3'd0, 8'd0, 8'd0)};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, ev(1, 0, 0, 0, 3'd0, 8'd0, 8'd0)};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, ev(1, 0, 0, 0, 3'd0, 8'd0, 8'd0)};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, ev(1, 0, 0, 0, 3'd0, 8'd0, 8'd0)};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, ev(0, 0, 0, 0, 3'd1, 8'd0, 8'd0)};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, ev(0, 0, 0, 0, 3'd1, 8'd0, 8'd0)};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, ev(0, 0, 0, 0, 3'd1, 8'd0, 8'd0)};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, ev(0, 0, 0, 0, 3'd1, 8'd0, 8'd0)};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, ev(0, 0, 0, 0, 3'd1, 8'd0, 8'd0)};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, ev(0, 0, 0, 0, 3'd1, 8'd0, 8'd0)};
    vecs[10] = '{1'b1, 1'b1, 1'b0, ev(0, 0, 0, 0, 3'd1, 8'd0, 8'd0)};
    vecs[11] = '{1'b1, 1'b1, 1'b0, ev(0, 0, 0, 0, 3'd1, 8'd0, 8'd0)};
    vecs[12] = '{1'b1, 1'b1, 1'b0, ev(0, 1, 0, 0, 3'd2, 8'd0, 8'd0)};
    vecs[13] = '{1'b1, 1'b1, 1'b0, ev(0, 1, 0, 0, 3'd2, 8'd0, 8'd0)};
    vecs[14] = '{1'b1, 1'b1, 1'b0, ev(0, 1, 0, 0, 3'd2, 8'd0, 8'd0)};
    vecs[15] = '{1'b1, 1'b1, 1'b0, ev(0, 1, 0, 0, 3'd2, 8'd0, 8'd0)};
    vecs[16] = '{1'b1, 1'b1, 1'b0, ev(0, 1, 1, 1, 3'd3, 8'd0, 8'd0)};
    vecs[17] = '{1'b1, 1'b1, 1'b0, ev(0, 1, 1, 1, 3'd3, 8'd0, 8'd0)};
    vecs[18] = '{1'b1, 1'b1, 1'b0, ev(0, 1, 1, 1, 3'd3, 8'd0, 8'd0)};

    step();
    for (int i = 0; i < 19; i++) begin
      reset_n      = vecs[i].rst_n;
      pll_locked   = vecs[i].lock;
      force_relock = vecs[i].frc;
      step();
      check($sformatf("clean_vec%0d", i), obs, vecs[i].exp);
    end

    // Lock loss in RUN: two sync stages keep RUN, third edge drops to PLL_RST.
    pll_locked = 1'b0;
    step(); check("loss_sync1", obs, ev(0, 1, 1, 1, 3'd3, 8'd0, 8'd0));
    step(); check("loss_sync2", obs, ev(0, 1, 1, 1, 3'd3, 8'd0, 8'd0));
    step(); check("loss_react", obs, ev(1, 0, 0, 0, 3'd0, 8'd1, 8'd0));

    // force_relock during PLL_RST is ignored: pll_rst stays exactly 4 cycles.
    pll_locked   = 1'b1;
    force_relock = 1'b1;
    step(); check("frc_in_rst", obs, ev(1, 0, 0, 0, 3'd0, 8'd1, 8'd0));
    force_relock = 1'b0;
    step_n(2); check("rst_hold3", obs, ev(1, 0, 0, 0, 3'd0, 8'd1, 8'd0));
    step(); check("rst_exit", obs, ev(0, 0, 0, 0, 3'd1, 8'd1, 8'd0));
    wait_state(3'd3, 40, "relock_run");
    check("relock_run_outs", obs, ev(0, 1, 1, 1, 3'd3, 8'd1, 8'd0));

    // force_relock in RUN: back to PLL_RST, counts untouched.
    force_relock = 1'b1;
    step();
    force_relock = 1'b0;
    check("frc_in_run", obs, ev(1, 0, 0, 0, 3'd0, 8'd1, 8'd0));
    wait_state(3'd3, 40, "frc_back_run");

    // force_relock coincident with the lock loss still counts the loss.
    pll_locked = 1'b0;
    step_n(2);
    force_relock = 1'b1;
    step();
    force_relock = 1'b0;
    check("frc_with_loss", obs, ev(1, 0, 0, 0, 3'd0, 8'd2, 8'd0));

    // Lock glitch: pll_locked low at edge 9 is seen by the FSM at edge 11
    // (stable count 6), restarting the count; release moves from 12 to 19.
    do_reset(1'b1);
    step_n(8);
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    step_n(3); check("glitch_e12", obs, ev(0, 0, 0, 0, 3'd1, 8'd0, 8'd0));
    step_n(6); check("glitch_e18", obs, ev(0, 0, 0, 0, 3'd1, 8'd0, 8'd0));
    step();    check("glitch_e19", obs, ev(0, 1, 0, 0, 3'd2, 8'd0, 8'd0));

    // Timeout with no lock: retries at edges 36, 72, 108.
    do_reset(1'b0);
    step_n(35); check("tmo_e35", obs, ev(0, 0, 0, 0, 3'd1, 8'd0, 8'd0));
    step();     check("tmo_e36", obs, ev(1, 0, 0, 0, 3'd0, 8'd0, 8'd1));
    step_n(3);  check("tmo_e39", obs, ev(1, 0, 0, 0, 3'd0, 8'd0, 8'd1));
    step();     check("tmo_e40", obs, ev(0, 0, 0, 0, 3'd1, 8'd0, 8'd1));
    step_n(31); check("tmo_e71", obs, ev(0, 0, 0, 0, 3'd1, 8'd0, 8'd1));
    step();     check("tmo_e72", obs, ev(1, 0, 0, 0, 3'd0, 8'd0, 8'd2));
    step_n(35); check("tmo_e107", obs, ev(0, 0, 0, 0, 3'd1, 8'd0, 8'd2));
    step();     check("tmo_e108", obs, ev(1, 0, 0, 0, 3'd0, 8'd0, 8'd3));

    // 256 lock losses in RELEASE_LOGIC: counter saturates at 255.
    do_reset(1'b1);
    for (int i = 0; i < 256; i++) begin
      pll_locked = 1'b1;
      wait_state(3'd2, 40, "sat_release");
      pll_locked = 1'b0;
      wait_state(3'd0, 10, "sat_loss");
      if (i == 254) check8("sat_255", lock_lost_count, 8'd255);
    end
    check8("sat_hold", lock_lost_count, 8'd255);

    // Asynchronous reset in RELEASE_LOGIC takes effect before the next edge.
    pll_locked = 1'b1;
    wait_state(3'd2, 40, "async_release");
    #1;
    reset_n = 1'b0;
    #1;
    check("async_rst", obs, ev(1, 0, 0, 0, 3'd0, 8'd0, 8'd0));
    step();
    reset_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
